// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef logic [IDX_W-1:0] arb_idx_t;

    function automatic logic [N-1:0] idx2onehot(arb_idx_t i);
        logic [N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesting engines and the arbiter.
interface rr_arbiter8_if
    import arb_pkg::*;
();

    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    arb_idx_t     gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/prio_enc8.sv
// Rotating 8-to-3 priority encoder: first set bit at or after ptr, wrapping.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [N-1:0] vec,
    input  arb_idx_t     ptr,
    output arb_idx_t     idx,
    output logic         valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    arb_idx_t       off;

    assign dbl = {vec, vec} >> ptr;
    assign rot = dbl[N-1:0];

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign idx   = off + ptr;
    assign valid = |vec;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters, grant held until done or request drop.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter8_if.slave     bus
);

    arb_state_t   state;
    arb_idx_t     ptr;
    arb_idx_t     win;
    logic         any;
    logic [N-1:0] gnt_q;
    arb_idx_t     idx_q;
    logic         valid_q;
    logic         rel_norm;
    logic         expire;
    logic         release_now;

    prio_enc8 u_enc (
        .vec   (bus.req),
        .ptr   (ptr),
        .idx   (win),
        .valid (any)
    );

    assign rel_norm    = bus.done | ~bus.req[idx_q];
    assign release_now = rel_norm | expire;

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold;
    logic              to_q;

    assign expire = (state == ARB_BUSY) &&
                    (hold == HOLD_W'(MAX_HOLD - 1));

    // A normal release in the expiry cycle suppresses the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            to_q <= 1'b0;
        end else begin
            to_q <= 1'b0;
            if (state == ARB_IDLE || rel_norm) begin
                hold <= '0;
            end else if (expire) begin
                hold <= '0;
                to_q <= 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end

    assign bus.timeout = to_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (any) begin
                        gnt_q   <= idx2onehot(win);
                        idx_q   <= win;
                        valid_q <= 1'b1;
                        state   <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (release_now) begin
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        ptr     <= idx_q + 1'b1;
                        state   <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8.
module tb_rr_arbiter8;
    import arb_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter8_if bif ();

    rr_arbiter8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bif.req  = 8'hFF;
        bif.done = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        checks++;
        if (bif.gnt !== 8'h00 || bif.gnt_idx !== 3'd0 ||
            bif.gnt_valid !== 1'b0 || bif.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%h idx=%0d v=%b to=%b",
                     bif.gnt, bif.gnt_idx, bif.gnt_valid, bif.timeout);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bif.gnt !== 8'h01 || bif.gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%h v=%b expected 01 1",
                     bif.gnt, bif.gnt_valid);
        end
        bif.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_hold_done();
        do_reset();
        bif.req = 8'h01;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (bif.gnt !== 8'h01 || bif.gnt_idx !== 3'd0) begin
                errors++;
                $display("FAIL hold_cycle%0d: gnt=%h idx=%0d expected 01 0",
                         c, bif.gnt, bif.gnt_idx);
            end
        end
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        checks++;
        if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_release: gnt=%h v=%b expected 00 0",
                     bif.gnt, bif.gnt_valid);
        end
        bif.req = 8'h03;
        tick();
        checks++;
        if (bif.gnt !== 8'h02 || bif.gnt_idx !== 3'd1) begin
            errors++;
            $display("FAIL ptr_advance: gnt=%h idx=%0d expected 02 1",
                     bif.gnt, bif.gnt_idx);
        end
        bif.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_oh;
        do_reset();
        bif.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_oh = 8'h01 << (k % 8);
            tick();
            checks++;
            if (bif.gnt_idx !== 3'(k % 8) || bif.gnt !== exp_oh) begin
                errors++;
                $display("FAIL rr_grant%0d: idx=%0d gnt=%h expected %0d %h",
                         k, bif.gnt_idx, bif.gnt, k % 8, exp_oh);
            end
            tick();
            tick();
            bif.done = 1'b1;
            tick();
            bif.done = 1'b0;
            checks++;
            if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_dead%0d: gnt=%h v=%b expected 00 0",
                         k, bif.gnt, bif.gnt_valid);
            end
        end
        bif.req = 8'h00;
        tick();
    endtask

    task automatic test_wrap_and_drop();
        do_reset();
        bif.req = 8'h20;
        tick();
        checks++;
        if (bif.gnt_idx !== 3'd5) begin
            errors++;
            $display("FAIL wrap_idx5: idx=%0d expected 5", bif.gnt_idx);
        end
        bif.req = 8'h00;
        tick();
        checks++;
        if (bif.gnt !== 8'h00) begin
            errors++;
            $display("FAIL drop_release: gnt=%h expected 00", bif.gnt);
        end
        bif.req = 8'b0010_0001;
        tick();
        checks++;
        if (bif.gnt_idx !== 3'd0 || bif.gnt !== 8'h01) begin
            errors++;
            $display("FAIL wrap_grant: idx=%0d gnt=%h expected 0 01",
                     bif.gnt_idx, bif.gnt);
        end
        bif.req = 8'hFF;
        tick();
        checks++;
        if (bif.gnt !== 8'h01) begin
            errors++;
            $display("FAIL ignore_others: gnt=%h expected 01", bif.gnt);
        end
        bif.req  = 8'h00;
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        checks++;
        if (bif.gnt !== 8'h00) begin
            errors++;
            $display("FAIL both_release: gnt=%h expected 00", bif.gnt);
        end
        tick();
    endtask

    task automatic test_idle_done();
        do_reset();
        bif.req  = 8'h00;
        bif.done = 1'b1;
        tick();
        tick();
        bif.done = 1'b0;
        checks++;
        if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: gnt=%h v=%b expected 00 0",
                     bif.gnt, bif.gnt_valid);
        end
        bif.req = 8'h80;
        tick();
        checks++;
        if (bif.gnt_idx !== 3'd7) begin
            errors++;
            $display("FAIL idle_done_ptr: idx=%0d expected 7", bif.gnt_idx);
        end
        bif.req = 8'h00;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bif.req = 8'h04;
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if (bif.gnt !== 8'h04 || bif.timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold%0d: gnt=%h to=%b expected 04 0",
                         c, bif.gnt, bif.timeout);
            end
        end
        tick();
        checks++;
        if (bif.gnt !== 8'h00 || bif.timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: gnt=%h to=%b expected 00 1",
                     bif.gnt, bif.timeout);
        end
        bif.req = 8'h0C;
        tick();
        checks++;
        if (bif.gnt_idx !== 3'd3 || bif.timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_ptr3: idx=%0d to=%b expected 3 0",
                     bif.gnt_idx, bif.timeout);
        end
        for (int c = 2; c <= 16; c++) tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        checks++;
        if (bif.gnt !== 8'h00 || bif.timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_done16: gnt=%h to=%b expected 00 0",
                     bif.gnt, bif.timeout);
        end
        bif.req = 8'h00;
        tick();
        tick();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        bif.req = 8'h04;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (bif.gnt !== 8'h04 || bif.timeout !== 1'b0) begin
                errors++;
                $display("FAIL no_to_hold%0d: gnt=%h to=%b expected 04 0",
                         c, bif.gnt, bif.timeout);
            end
        end
        bif.req = 8'h00;
        tick();
        tick();
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        bif.req = 8'h40;
        tick();
        checks++;
        if (bif.gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL ar_idx6: idx=%0d expected 6", bif.gnt_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_drop: gnt=%h v=%b expected 00 0",
                     bif.gnt, bif.gnt_valid);
        end
        rst_n   = 1'b1;
        bif.req = 8'hC1;
        tick();
        checks++;
        if (bif.gnt_idx !== 3'd0 || bif.gnt !== 8'h01) begin
            errors++;
            $display("FAIL ar_ptr0: idx=%0d gnt=%h expected 0 01",
                     bif.gnt_idx, bif.gnt);
        end
        bif.req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bif.req  = '0;
        bif.done = 1'b0;
        test_reset();
        test_hold_done();
        test_round_robin();
        test_wrap_and_drop();
        test_idle_done();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
